// File: rtl/scanline_sched.sv
// Per-line scanline-darkening scheduler: follows hs/vs/de, picks the darkening level
// for each output line, latches user config at frame starts and reports frame lock.
module scanline_sched #(
    parameter int LINE_W    = 12,
    parameter int MAX_LINES = 2047
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mode,
    input  logic [1:0]        period,
    input  logic              hs_in,
    input  logic              vs_in,
    input  logic              de_in,
    output logic [1:0]        level,
    output logic [LINE_W-1:0] frame_lines,
    output logic              locked,
    output logic              cfg_applied
);

    // state | meaning
    // SYNC  | waiting for a vs fall; level held 0, no line counting
    // RUN   | tracking lines, phase and frame length
    typedef enum logic {SYNC, RUN} state_t;

    localparam logic [LINE_W-1:0] WD_LAST = LINE_W'(MAX_LINES - 1);

    state_t            state_q, state_d;
    logic              old_hs, old_vs;
    logic              hs_fall, vs_fall;
    logic              de_seen;
    logic [1:0]        shadow_mode, shadow_period;
    logic [1:0]        phase, phase_adv;
    logic [LINE_W-1:0] line_cnt, line_inc, fl_new;
    logic [LINE_W-1:0] wd_cnt;
    logic              wd_hit;

    assign hs_fall = old_hs & ~hs_in;
    assign vs_fall = old_vs & ~vs_in;

    assign phase_adv = (phase == shadow_period) ? 2'd0 : 2'(phase + 2'd1);
    assign line_inc  = (&line_cnt) ? line_cnt : line_cnt + 1'b1;
    // The line ending on a vs fall still counts if it carried data.
    assign fl_new    = de_seen ? line_inc : line_cnt;

    always_comb begin
        state_d = state_q;
        wd_hit  = 1'b0;
        case (state_q)
            SYNC: begin
                if (vs_fall) state_d = RUN;
            end
            RUN: begin
                if (hs_fall && !vs_fall && (wd_cnt == WD_LAST)) begin
                    wd_hit  = 1'b1;
                    state_d = SYNC;
                end
            end
            default: state_d = SYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= SYNC;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            old_hs        <= 1'b0;
            old_vs        <= 1'b0;
            de_seen       <= 1'b0;
            shadow_mode   <= 2'd0;
            shadow_period <= 2'd0;
            phase         <= 2'd0;
            line_cnt      <= '0;
            wd_cnt        <= '0;
            level         <= 2'd0;
            frame_lines   <= '0;
            locked        <= 1'b0;
            cfg_applied   <= 1'b0;
        end else begin
            old_hs      <= hs_in;
            old_vs      <= vs_in;
            de_seen     <= hs_fall ? 1'b0 : (de_seen | de_in);
            cfg_applied <= vs_fall;

            if (vs_fall) begin
                shadow_mode   <= mode;
                shadow_period <= period;
                phase         <= 2'd0;
                level         <= (period == 2'd0) ? mode : 2'd0;
                line_cnt      <= '0;
                wd_cnt        <= '0;
                if (state_q == RUN) begin
                    frame_lines <= fl_new;
                    locked      <= (fl_new == frame_lines) && (fl_new != '0);
                end
            end else if ((state_q == RUN) && hs_fall) begin
                if (wd_hit) begin
                    level    <= 2'd0;
                    locked   <= 1'b0;
                    phase    <= 2'd0;
                    line_cnt <= '0;
                    wd_cnt   <= '0;
                end else begin
                    wd_cnt <= wd_cnt + 1'b1;
                    if (de_seen) begin
                        line_cnt <= line_inc;
                        phase    <= phase_adv;
                        level    <= (phase_adv == shadow_period) ? shadow_mode : 2'd0;
                    end else begin
                        // Blanking line: phase holds, level re-derived from it.
                        level <= (phase == shadow_period) ? shadow_mode : 2'd0;
                    end
                end
            end
        end
    end

endmodule
